// File: rtl/if_id_fetch_ctrl.sv
// Fetch control: owns the PC, a single-outstanding instruction fetch
// handshake with a one-entry skid buffer, and the IF/ID pipeline register.
// Reacts to the hazard unit's stall and the EX-stage branch flush, and
// drives the bubble that zeroes the ID/EX control fields.
module if_id_fetch_ctrl #(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inStall,
  input  logic                      inFlush,
  input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
  input  logic                      inFetchValid,
  input  logic [31:0]               inFetchIns,
  output logic                      outFetchReq,
  output logic [BUS_DATA_WIDTH-1:0] outFetchAddr,
  output logic [BUS_DATA_WIDTH-1:0] outPC,
  output logic [31:0]               outIdIns,
  output logic [BUS_DATA_WIDTH-1:0] outIdPC,
  output logic                      outIdValid,
  output logic                      outBubble,
  output logic [31:0]               outStallCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } state_t;

  state_t                    state_reg, state_next;
  logic [BUS_DATA_WIDTH-1:0] pc_reg, pc_next, pc_plus4;
  logic [31:0]               skid_reg, skid_next;
  logic [31:0]               id_ins_reg;
  logic [BUS_DATA_WIDTH-1:0] id_pc_reg;
  logic                      id_valid_reg;
  logic [31:0]               stall_cnt_reg;

  // id_load marks a cycle where a fresh instruction enters IF/ID; the word
  // comes either straight from memory or from the skid buffer.
  logic                      id_load;
  logic [31:0]               id_load_ins;

  // PC wraps naturally modulo 2^BUS_DATA_WIDTH.
  assign pc_plus4 = pc_reg + BUS_DATA_WIDTH'(4);

  // State, PC and skid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      skid_reg  <= skid_next;
    end
  end

  // Next-state / PC / skid decisions; flush always outranks stall.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    skid_next   = skid_reg;
    id_load     = 1'b0;
    id_load_ins = inFetchIns;
    case (state_reg)
      IDLE: begin
        if (inFlush) pc_next = inBranchTarget;
        state_next = ISSUE;
      end
      ISSUE: begin
        if (inFlush) begin
          // The request just issued is now stale; drain its response.
          pc_next    = inBranchTarget;
          state_next = DROP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (inFetchValid) begin
          if (inFlush) begin
            pc_next    = inBranchTarget;
            state_next = ISSUE;
          end else if (inStall) begin
            skid_next  = inFetchIns;
            state_next = HOLD;
          end else begin
            id_load    = 1'b1;
            pc_next    = pc_plus4;
            state_next = ISSUE;
          end
        end else if (inFlush) begin
          pc_next    = inBranchTarget;
          state_next = DROP;
        end
      end
      HOLD: begin
        if (inFlush) begin
          pc_next    = inBranchTarget;
          state_next = ISSUE;
        end else if (!inStall) begin
          id_load     = 1'b1;
          id_load_ins = skid_reg;
          pc_next     = pc_plus4;
          state_next  = ISSUE;
        end
      end
      DROP: begin
        // A further redirect only moves the PC; the stale response still
        // has to be consumed before the next request goes out.
        if (inFlush) pc_next = inBranchTarget;
        if (inFetchValid) state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  // IF/ID pipeline register: flush clears, stall freezes, otherwise the
  // slot is live only on cycles that deliver a new instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ins_reg   <= '0;
      id_pc_reg    <= '0;
      id_valid_reg <= 1'b0;
    end else if (inFlush) begin
      id_valid_reg <= 1'b0;
    end else if (inStall) begin
      id_valid_reg <= id_valid_reg;
    end else if (id_load) begin
      id_ins_reg   <= id_load_ins;
      id_pc_reg    <= pc_reg;
      id_valid_reg <= 1'b1;
    end else begin
      id_valid_reg <= 1'b0;
    end
  end

  // Saturating count of effective (non-flushed) stall cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (inStall && !inFlush && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign outFetchReq   = (state_reg == ISSUE);
  assign outFetchAddr  = pc_reg;
  assign outPC         = pc_reg;
  assign outIdIns      = id_ins_reg;
  assign outIdPC       = id_pc_reg;
  assign outIdValid    = id_valid_reg;
  assign outBubble     = inStall | inFlush | ~id_valid_reg;
  assign outStallCount = stall_cnt_reg;

endmodule
